// File: rtl/frame_generator_impl.sv
// frame_generator_impl: IPv4 test-frame generator on a 512-bit AXI-Stream master.
// Header and LFSR payload are laid out for the per-port frame checker.
module ip_header_checksum (
  input  logic [159:0] i_hdr,
  output logic [15:0]  o_csum
);
  logic [19:0] w_sum;
  logic [16:0] w_f1;
  logic [15:0] w_f2;
  always_comb begin
    w_sum = '0;
    for (int j = 0; j < 10; j++) w_sum = w_sum + {4'd0, i_hdr[16*j +: 8], i_hdr[16*j+8 +: 8]};
  end
  assign w_f1   = {1'b0, w_sum[15:0]} + {13'd0, w_sum[19:16]};
  assign w_f2   = w_f1[15:0] + {15'd0, w_f1[16]};
  assign o_csum = ~w_f2;
endmodule

module frame_generator_impl #(
  parameter int                  DATA_WIDTH       = 512,
  parameter int                  ID_WIDTH         = 3,
  parameter logic [ID_WIDTH-1:0] PORT_ID          = '0,
  parameter logic [7:0]          TEST_FRAME_TOS   = 8'h00,
  parameter logic [7:0]          TEST_FRAME_PROTO = 8'hFD
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    ready,
  input  logic                    start,
  input  logic                    stop,
  input  logic [10:0]             cfg_frame_len,
  input  logic [15:0]             cfg_gap,
  input  logic [31:0]             cfg_frame_count,
  input  logic [15:0]             cfg_seed,
  input  logic [47:0]             cfg_dst_mac,
  input  logic [47:0]             cfg_src_mac,
  input  logic [31:0]             cfg_src_ip,
  input  logic [31:0]             cfg_dst_ip,
  output logic [31:0]             tx_frames,
  output logic [47:0]             tx_bytes,
  output logic [DATA_WIDTH-1:0]   axis_m_data,
  output logic [DATA_WIDTH/8-1:0] axis_m_keep,
  output logic                    axis_m_last,
  output logic [63:0]             axis_m_user,
  output logic [ID_WIDTH-1:0]     axis_m_id,
  output logic                    axis_m_valid,
  input  logic                    axis_m_ready
);
  localparam int KW = DATA_WIDTH / 8;
  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_BODY, S_GAP} state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  state_t                r_state, w_next;
  logic [10:0]           r_len, w_len, w_clamp;
  logic [15:0]           r_gap, r_gcnt, r_id, r_p, w_nid, w_tot, w_csum;
  logic [31:0]           r_count, r_frames, r_sip, r_dip, w_sip, w_dip;
  logic [47:0]           r_bytes, r_dmac, r_smac, w_dmac, w_smac;
  logic [4:0]            r_beat;
  logic [5:0]            w_nbeats;
  logic                  r_stop, r_valid, r_last, r_ready, w_last;
  logic                  w_idle, w_go, w_hs, w_fin, w_quota, w_body_last, w_ld_hdr, w_ld_body;
  logic [DATA_WIDTH-1:0] r_data, w_data, w_hdr;
  logic [KW-1:0]         r_keep, w_keep, w_mask;
  logic [159:0]          w_ip;

  // While idle the header is built straight from the cfg inputs so the first beat can be registered on the start edge
  assign w_idle      = r_state == S_IDLE;
  assign w_go        = w_idle & start & ~stop;
  assign w_clamp     = (cfg_frame_len < 11'd60) ? 11'd60 : (cfg_frame_len > 11'd1514) ? 11'd1514 : cfg_frame_len;
  assign w_len       = w_idle ? w_clamp : r_len;
  assign w_dmac      = w_idle ? cfg_dst_mac : r_dmac;
  assign w_smac      = w_idle ? cfg_src_mac : r_smac;
  assign w_sip       = w_idle ? cfg_src_ip : r_sip;
  assign w_dip       = w_idle ? cfg_dst_ip : r_dip;
  assign w_nid       = w_idle ? ((cfg_seed == 16'd0) ? 16'd1 : cfg_seed) : lfsr_next(r_id);
  assign w_tot       = {5'd0, w_len} - 16'd14;
  assign w_nbeats    = 6'(({1'b0, r_len} + 12'd63) >> 6);
  assign w_body_last = ({1'b0, r_beat} + 6'd2) == w_nbeats;
  assign w_mask      = (w_len[5:0] == 6'd0) ? '1 : ~({KW{1'b1}} << w_len[5:0]);
  assign w_hs        = r_valid & axis_m_ready;
  assign w_fin       = w_hs & r_last;
  assign w_quota     = (r_count != 32'd0) && (r_frames + 32'd1 == r_count);

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;

  always_comb begin
    w_next    = r_state;
    w_ld_hdr  = 1'b0;
    w_ld_body = 1'b0;
    case (r_state)
      S_IDLE: if (w_go) begin
        w_next   = S_FIRST;
        w_ld_hdr = 1'b1;
      end
      S_FIRST, S_BODY: if (w_hs) begin
        if (!r_last) begin
          w_next    = S_BODY;
          w_ld_body = 1'b1;
        end else if (r_stop || stop || w_quota) w_next = S_IDLE;
        else if (r_gap != 16'd0) w_next = S_GAP;
        else begin
          w_next   = S_FIRST;
          w_ld_hdr = 1'b1;
        end
      end
      default: if (r_stop || stop) w_next = S_IDLE;
      else if (r_gcnt == r_gap - 16'd1) begin
        w_next   = S_FIRST;
        w_ld_hdr = 1'b1;
      end
    endcase
  end

  // IPv4 header bytes 14..33 with the checksum field zeroed
  always_comb begin
    w_ip          = '0;
    w_ip[7:0]     = 8'h45;
    w_ip[15:8]    = TEST_FRAME_TOS;
    w_ip[31:16]   = {w_tot[7:0], w_tot[15:8]};
    w_ip[47:32]   = w_nid;
    w_ip[71:64]   = 8'd64;
    w_ip[79:72]   = TEST_FRAME_PROTO;
    for (int i = 0; i < 4; i++) begin
      w_ip[96+8*i +: 8]  = w_sip[31-8*i -: 8];
      w_ip[128+8*i +: 8] = w_dip[31-8*i -: 8];
    end
  end

  ip_header_checksum u_csum (.i_hdr(w_ip), .o_csum(w_csum));

  always_comb begin
    w_hdr = {DATA_WIDTH/16{w_nid}};
    for (int i = 0; i < 6; i++) begin
      w_hdr[8*i +: 8]    = w_dmac[47-8*i -: 8];
      w_hdr[48+8*i +: 8] = w_smac[47-8*i -: 8];
    end
    w_hdr[111:96]  = 16'h0008;
    w_hdr[271:112] = w_ip;
    w_hdr[207:192] = {w_csum[7:0], w_csum[15:8]};
    w_data         = w_ld_hdr ? w_hdr : {DATA_WIDTH/16{lfsr_next(r_p)}};
    w_last         = w_ld_hdr ? (w_len <= 11'd64) : w_body_last;
    w_keep         = w_last ? w_mask : '1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {r_len, r_gap, r_count, r_dmac, r_smac, r_sip, r_dip} <= '0;
      {r_id, r_p, r_beat, r_gcnt, r_frames, r_bytes, r_stop} <= '0;
      {r_valid, r_data, r_keep, r_last} <= '0;
      r_ready <= 1'b1;
    end else begin
      r_ready <= w_next == S_IDLE;
      r_valid <= (w_next == S_FIRST) || (w_next == S_BODY);
      r_stop  <= (w_next == S_IDLE) ? 1'b0 : (r_stop | (stop & ~w_idle));
      r_gcnt  <= (r_state == S_GAP) ? r_gcnt + 16'd1 : 16'd0;
      if (w_ld_hdr || w_ld_body) begin
        r_data <= w_data;
        r_keep <= w_keep;
        r_last <= w_last;
      end
      if (w_ld_hdr) begin
        r_id   <= w_nid;
        r_p    <= w_nid;
        r_beat <= 5'd0;
      end
      if (w_ld_body) begin
        r_p    <= lfsr_next(r_p);
        r_beat <= r_beat + 5'd1;
      end
      if (w_go) begin
        {r_len, r_gap, r_count} <= {w_clamp, cfg_gap, cfg_frame_count};
        {r_dmac, r_smac, r_sip, r_dip} <= {cfg_dst_mac, cfg_src_mac, cfg_src_ip, cfg_dst_ip};
        r_frames <= '0;
        r_bytes  <= '0;
      end else if (w_fin) begin
        r_frames <= r_frames + 32'd1;
        r_bytes  <= r_bytes + {37'd0, r_len};
      end
    end

  assign ready        = r_ready;
  assign tx_frames    = r_frames;
  assign tx_bytes     = r_bytes;
  assign axis_m_data  = r_data;
  assign axis_m_keep  = r_keep;
  assign axis_m_last  = r_last;
  assign axis_m_valid = r_valid;
  assign axis_m_user  = '0;
  assign axis_m_id    = PORT_ID;
endmodule

// File: tb/tb_frame_generator_impl.sv
// tb_frame_generator_impl: directed vector table plus multi-cycle sequences for frame_generator_impl.
module tb_frame_generator_impl;
  localparam logic [47:0] DMAC = 48'h0011_2233_4455;
  localparam logic [47:0] SMAC = 48'h0A0B_0C0D_0E0F;
  localparam logic [31:0] SIP  = 32'hC0A8_0001;
  localparam logic [31:0] DIP  = 32'hC0A8_0002;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [10:0]  cfg_frame_len = 11'd60;
  logic [15:0]  cfg_gap = '0, cfg_seed = 16'd1;
  logic [31:0]  cfg_frame_count = 32'd1;
  logic [47:0]  cfg_dst_mac = DMAC, cfg_src_mac = SMAC;
  logic [31:0]  cfg_src_ip = SIP, cfg_dst_ip = DIP;
  logic         ready, axis_m_last, axis_m_valid;
  logic [31:0]  tx_frames;
  logic [47:0]  tx_bytes;
  logic [511:0] axis_m_data;
  logic [63:0]  axis_m_keep, axis_m_user;
  logic [2:0]   axis_m_id;
  logic         axis_m_ready = 1'b1;
  bit           rnd_en = 1'b0;

  frame_generator_impl #(.PORT_ID(3'd5)) dut (
    .clk(clk), .rst(rst), .ready(ready), .start(start), .stop(stop),
    .cfg_frame_len(cfg_frame_len), .cfg_gap(cfg_gap), .cfg_frame_count(cfg_frame_count),
    .cfg_seed(cfg_seed), .cfg_dst_mac(cfg_dst_mac), .cfg_src_mac(cfg_src_mac),
    .cfg_src_ip(cfg_src_ip), .cfg_dst_ip(cfg_dst_ip), .tx_frames(tx_frames), .tx_bytes(tx_bytes),
    .axis_m_data(axis_m_data), .axis_m_keep(axis_m_keep), .axis_m_last(axis_m_last),
    .axis_m_user(axis_m_user), .axis_m_id(axis_m_id), .axis_m_valid(axis_m_valid),
    .axis_m_ready(axis_m_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    axis_m_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Beat log, hold-rule watcher and inter-frame idle-run recorder
  logic [511:0] q_data[$];
  logic [63:0]  q_keep[$], q_user[$];
  logic         q_last[$];
  logic [2:0]   q_tid[$];
  int           q_gaps[$];
  logic         pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [511:0] pd;
  logic [63:0]  pk;
  int           hold_bad = 0, vcount = 0, grun = 0;
  bit           gflag = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
      gflag = 1'b0;
    end else begin
      if (pv && !pr && (!axis_m_valid || axis_m_data !== pd || axis_m_keep !== pk || axis_m_last !== pl))
        hold_bad++;
      if (axis_m_valid) vcount++;
      if (ready) gflag = 1'b0;
      else if (gflag) begin
        if (axis_m_valid) begin
          q_gaps.push_back(grun);
          gflag = 1'b0;
        end else grun++;
      end
      if (axis_m_valid && axis_m_ready) begin
        q_data.push_back(axis_m_data);
        q_keep.push_back(axis_m_keep);
        q_last.push_back(axis_m_last);
        q_user.push_back(axis_m_user);
        q_tid.push_back(axis_m_id);
        if (axis_m_last) begin
          gflag = 1'b1;
          grun = 0;
        end
      end
      pv = axis_m_valid;
      pr = axis_m_ready;
      pd = axis_m_data;
      pk = axis_m_keep;
      pl = axis_m_last;
    end
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] nxt(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  task automatic setcfg(input int len, input logic [15:0] seed, input int gap, input int count);
    cfg_frame_len   = 11'(len);
    cfg_seed        = seed;
    cfg_gap         = 16'(gap);
    cfg_frame_count = 32'(count);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ready) break;
    end
    chk(nm, 64'(i < 3000), 64'd1);
  endtask

  task automatic wait_beats(input int n);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (q_data.size() >= n) break;
    end
    chk("beat_wait", 64'(i < 3000), 64'd1);
  endtask

  task automatic check_frame(input int b, input logic [15:0] id, input int len);
    int nb;
    logic [15:0] p, tot;
    logic [511:0] d, e, m;
    logic [63:0] ek;
    logic [19:0] s;
    logic [47:0] dm, sm;
    logic [31:0] si, di;
    nb = (len + 63) / 64;
    p = id;
    tot = 16'(len - 14);
    dm = DMAC; sm = SMAC; si = SIP; di = DIP;
    if (q_data.size() < b + nb) begin
      chk("frame_beats", 64'(q_data.size() - b), 64'(nb));
      return;
    end
    for (int k = 0; k < nb; k++) begin
      d = q_data[b+k];
      ek = (k == nb - 1 && len % 64 != 0) ? (64'd1 << (len % 64)) - 64'd1 : '1;
      chk("keep", q_keep[b+k], ek);
      chk("last", 64'(q_last[b+k]), 64'(k == nb - 1));
      chk("user", q_user[b+k], 64'd0);
      chk("tid", 64'(q_tid[b+k]), 64'd5);
      if (k == 0) begin
        e = {32{p}};
        for (int i = 0; i < 6; i++) begin
          e[8*i +: 8] = dm[47-8*i -: 8];
          e[48+8*i +: 8] = sm[47-8*i -: 8];
        end
        e[103:96] = 8'h08; e[111:104] = 8'h00; e[119:112] = 8'h45; e[127:120] = 8'h00;
        e[135:128] = tot[15:8]; e[143:136] = tot[7:0];
        e[151:144] = id[7:0]; e[159:152] = id[15:8];
        e[175:160] = 16'h0000; e[183:176] = 8'd64; e[191:184] = 8'hFD;
        for (int i = 0; i < 4; i++) begin
          e[208+8*i +: 8] = si[31-8*i -: 8];
          e[240+8*i +: 8] = di[31-8*i -: 8];
        end
        m = '1;
        m[207:192] = 16'h0000;
        chkw("header", d & m, e & m);
        s = '0;
        for (int j = 0; j < 10; j++) s = s + {4'd0, d[112+16*j +: 8], d[120+16*j +: 8]};
        s = {4'd0, s[15:0]} + {16'd0, s[19:16]};
        s = {4'd0, s[15:0]} + {16'd0, s[19:16]};
        chk("ip_csum", 64'(s), 64'hFFFF);
      end else begin
        p = nxt(p);
        chkw("payload", d, {32{p}});
      end
    end
  endtask

  typedef struct {
    int          len;
    logic [15:0] seed;
    logic [15:0] id;
    int          elen;
    int          beats;
    logic [63:0] lkeep;
  } vec_t;

  vec_t tv[7];
  int b, g, h, v0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{60,   16'h0001, 16'h0001, 60,   1,  64'h0FFF_FFFF_FFFF_FFFF};
    tv[1] = '{129,  16'h0001, 16'h0001, 129,  3,  64'h0000_0000_0000_0001};
    tv[2] = '{20,   16'h0000, 16'h0001, 60,   1,  64'h0FFF_FFFF_FFFF_FFFF};
    tv[3] = '{2000, 16'hBEEF, 16'hBEEF, 1514, 24, 64'h0000_03FF_FFFF_FFFF};
    tv[4] = '{128,  16'h1234, 16'h1234, 128,  2,  64'hFFFF_FFFF_FFFF_FFFF};
    tv[5] = '{64,   16'hFFFF, 16'hFFFF, 64,   1,  64'hFFFF_FFFF_FFFF_FFFF};
    tv[6] = '{65,   16'h00A5, 16'h00A5, 65,   2,  64'h0000_0000_0000_0001};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_valid", 64'(axis_m_valid), 64'd0);
    chkw("rst_data", axis_m_data, '0);
    chk("rst_keep", axis_m_keep, 64'd0);
    chk("rst_last", 64'(axis_m_last), 64'd0);
    chk("rst_frames", 64'(tx_frames), 64'd0);
    chk("rst_bytes", 64'(tx_bytes), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      setcfg(tv[i].len, tv[i].seed, 0, 1);
      b = q_data.size();
      pulse_start();
      chk("first_beat_latency", 64'(axis_m_valid), 64'd1);
      wait_idle("single_done");
      chk("beats", 64'(q_data.size() - b), 64'(tv[i].beats));
      check_frame(b, tv[i].id, tv[i].elen);
      if (q_keep.size() >= b + tv[i].beats) chk("last_keep", q_keep[b + tv[i].beats - 1], tv[i].lkeep);
      chk("tx_frames", 64'(tx_frames), 64'd1);
      chk("tx_bytes", 64'(tx_bytes), 64'(tv[i].elen));
    end

    // Back-to-back max-length frames under random backpressure
    setcfg(1514, 16'h0001, 0, 3);
    b = q_data.size(); g = q_gaps.size(); h = hold_bad;
    rnd_en = 1'b1;
    pulse_start();
    wait_idle("b2b_done");
    rnd_en = 1'b0;
    chk("b2b_beats", 64'(q_data.size() - b), 64'd72);
    check_frame(b, 16'h0001, 1514);
    check_frame(b + 24, 16'h8000, 1514);
    check_frame(b + 48, 16'h4000, 1514);
    chk("b2b_gap_count", 64'(q_gaps.size() - g), 64'd2);
    for (int i = g; i < q_gaps.size(); i++) chk("b2b_gap_len", 64'(q_gaps[i]), 64'd0);
    chk("b2b_frames", 64'(tx_frames), 64'd3);
    chk("b2b_bytes", 64'(tx_bytes), 64'd4542);
    chk("hold_violations", 64'(hold_bad - h), 64'd0);

    // Gap of 5, unlimited count, stop during the body of frame 2
    setcfg(100, 16'h0001, 5, 0);
    b = q_data.size(); g = q_gaps.size();
    pulse_start();
    wait_beats(b + 3);
    stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    wait_idle("stop_done");
    repeat (10) @(negedge clk);
    chk("stop_beats", 64'(q_data.size() - b), 64'd4);
    check_frame(b, 16'h0001, 100);
    check_frame(b + 2, 16'h8000, 100);
    chk("gap_count", 64'(q_gaps.size() - g), 64'd1);
    if (q_gaps.size() > g) chk("gap_len", 64'(q_gaps[g]), 64'd5);
    chk("stop_frames", 64'(tx_frames), 64'd2);
    chk("stop_bytes", 64'(tx_bytes), 64'd200);

    // start and stop together: stop wins
    setcfg(60, 16'h0001, 0, 1);
    v0 = vcount;
    @(posedge clk); #1 begin start = 1'b1; stop = 1'b1; end
    @(posedge clk); #1 begin start = 1'b0; stop = 1'b0; end
    repeat (10) @(negedge clk);
    chk("startstop_valid", 64'(vcount - v0), 64'd0);
    chk("startstop_ready", 64'(ready), 64'd1);

    // Reset in the body of frame 2, then a fresh frame 0
    setcfg(129, 16'h0001, 0, 0);
    b = q_data.size();
    pulse_start();
    wait_beats(b + 7);
    chk("pre_rst_frames", 64'(tx_frames), 64'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(axis_m_valid), 64'd0);
    chk("mid_rst_frames", 64'(tx_frames), 64'd0);
    chk("mid_rst_bytes", 64'(tx_bytes), 64'd0);
    chk("mid_rst_ready", 64'(ready), 64'd1);
    check_frame(b, 16'h0001, 129);
    check_frame(b + 3, 16'h8000, 129);
    @(posedge clk); #1 rst = 1'b0;
    setcfg(60, 16'h0000, 0, 1);
    b = q_data.size();
    pulse_start();
    wait_idle("post_rst_done");
    chk("post_rst_beats", 64'(q_data.size() - b), 64'd1);
    check_frame(b, 16'h0001, 60);
    chk("post_rst_frames", 64'(tx_frames), 64'd1);
    chk("post_rst_bytes", 64'(tx_bytes), 64'd60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/frame_generator_impl.md
# frame_generator_impl

Transmit-side counterpart of the per-port frame checker: generates IPv4 test frames on a 512-bit AXI-Stream master toward the port TX path, with header fields and LFSR-derived payload laid out exactly as the checker verifies them. Runs between `start` and `stop`, paces frames with a configurable inter-frame gap, and accumulates transmitted frame/byte counts. One instance per tester port.

## Interface
- `DATA_WIDTH`, 512, AXIS data width in bits (block requires 512).
- `ID_WIDTH`, 3, AXIS TID width.
- `PORT_ID`, 0, constant driven on `axis_m_id`.
- `clk` input 1: clock; one clock for the block.
- `rst` input 1: reset, asynchronous, active-high.
- `ready` output 1: high in IDLE; accepts `start`.
- `start` input 1: single-cycle pulse; latches config, clears counters, begins generation.
- `stop` input 1: single-cycle pulse; ends generation after the current frame.
- `cfg_frame_len` input 11: frame length in bytes, excluding FCS.
- `cfg_gap` input 16: idle cycles between frames.
- `cfg_frame_count` input 32: frames to send; 0 = unlimited.
- `cfg_seed` input 16: id/LFSR seed of the first frame.
- `cfg_dst_mac`, `cfg_src_mac` input 48 each; `cfg_src_ip`, `cfg_dst_ip` input 32 each.
- `tx_frames` output 32, `tx_bytes` output 48: counts of completed frames.
- `axis_m_data` output 512, `axis_m_keep` output 64, `axis_m_last` output 1, `axis_m_user` output 64, `axis_m_id` output ID_WIDTH, `axis_m_valid` output 1, `axis_m_ready` input 1.

## Operation
- States: IDLE, FIRST (header beat), BODY, GAP.
- IDLE: `ready`=1. `start` latches all cfg inputs, zeroes counters, and moves to FIRST. If `start` and `stop` arrive together, stop wins and the block stays in IDLE. `start` outside IDLE is ignored.
- Length is clamped to 60..1514. Beats = ceil(len/64).
- Keep: full (all ones) on non-last beats. On the last beat, the low r bits are set, where r = len mod 64; r = 0 means full.
- `axis_m_user`=0 always. `axis_m_id`=PORT_ID always.
- First-beat byte lanes (lane 0 is first on wire):
  - 0–5 dst MAC, 6–11 src MAC (MSB first).
  - 12–13 = 08 00.
  - 14 = 0x45, 15 = TEST_FRAME_TOS.
  - 16–17 = len−14, big-endian.
  - 18 = id[7:0], 19 = id[15:8].
  - 20–21 = 00 00.
  - 22 = 64 (TTL), 23 = TEST_FRAME_PROTO.
  - 24–25 = checksum from an `ip_header_checksum` instance over the assembled header.
  - 26–29 src IP, 30–33 dst IP.
  - 34–63 payload.
- Payload: beat k carries the 16-bit value P_k replicated across all lanes. Even lane = P_k[7:0], odd lane = P_k[15:8].
  - P_0 = id.
  - P_{k+1} = next(P_k), with next(l) = {l[0]^l[2]^l[3]^l[5], l[15:1]}.
- Frame id: frame 0 uses `cfg_seed`, with 0 replaced by 0x0001. Each following frame's id = next(previous id).
- FIRST → BODY after the handshake when beats > 1; otherwise it follows the last-beat rule.
- BODY → (last beat handshake):
  - IDLE if stop is pending or `tx_frames`+1 = `cfg_frame_count` ≠ 0;
  - else GAP if `cfg_gap` > 0;
  - else FIRST.
- GAP: counts `cfg_gap` cycles with valid low, then goes to FIRST. A pending stop in GAP goes to IDLE immediately.
- `stop` during FIRST/BODY is recorded as pending. The frame is never truncated.
- Counters update on the last-beat handshake: `tx_frames`+1, `tx_bytes`+clamped len. Both wrap modulo 2^width.

## Timing
- All AXIS outputs and `ready` are registered.
- `start` accepted at cycle N → first beat valid at N+1.
- AXIS rule: once valid is high, data/keep/last are held stable until `axis_m_ready`. Valid is never withdrawn without a handshake.
- One beat per cycle while `axis_m_ready`=1.
- Gap 0: next frame's first beat in the cycle after the last-beat handshake (back-to-back).
- Gap g: valid low for exactly g cycles.
- Counters are visible the cycle after the last-beat handshake.
- Reset values (asynchronous): state IDLE, `ready`=1, `axis_m_valid`=0, data/keep/last/user=0, counters=0, pending stop cleared.
- Reset mid-frame: the frame is abandoned and no partial count is recorded.

## Test plan
- len=60, seed=0x0001, count=1, ready=1 → one beat:
  - keep=0x0FFF_FFFF_FFFF_FFFF, last=1;
  - lanes 18/19=01/00, lanes 34..59 alternate 01,00;
  - header checksum valid; `tx_frames`=1, `tx_bytes`=60; returns to IDLE.
- len=129, seed=0x0001 → 3 beats:
  - beat1 all lanes 00,80 (P=0x8000); beat2 P=0x4000;
  - last keep=0x1; lanes 16–17 = 00 73.
- len=1514, gap=0, count=3, ready toggling randomly → 24 beats per frame, no idle cycles between frames, frame ids 0x0001/0x8000/0x4000, `tx_bytes`=4542, data stable whenever valid && !ready.
- gap=5, count=0, `stop` asserted mid-frame 2 → frame 2 completes intact, then IDLE; exactly 5 idle cycles between frames; `tx_frames`=2.
- len=20 (clamped to 60) and seed=0 → 60-byte frame with id 0x0001. `start`+`stop` in the same cycle → no valid asserted.
- Assert `rst` mid-BODY → valid drops immediately, counters 0, ready=1. A new `start` produces a correct frame 0.
